// File: rtl/serial_sub_restorer_if.sv
// Start/done handshake bundle for the serial minuend restorer.
// The master drives the request and operands; the slave returns status and the result.
interface serial_sub_restorer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] difference;
  logic [WIDTH-1:0] b;
  logic             bout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_out;
  logic             mismatch;

  modport master (
    output start, difference, b, bout,
    input  busy, done, a_out, mismatch
  );

  modport slave (
    input  start, difference, b, bout,
    output busy, done, a_out, mismatch
  );
endinterface

// File: rtl/serial_sub_restorer.sv
// Rebuilds the minuend of a subtraction bit-serially as difference + b, LSB first,
// and flags when the final carry disagrees with the reported borrow.
module serial_sub_restorer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_sub_restorer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] diffReg_q;
  logic [WIDTH-1:0] bReg_q;
  logic [WIDTH-1:0] resReg_q;
  logic [WIDTH-1:0] aOut_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             boutReg_q;
  logic             busy_q;
  logic             done_q;
  logic             mismatch_q;

  logic             sum_d;
  logic             carry_d;

  // One full-adder slice acting on the current LSBs of the operand shifters.
  always_comb begin
    sum_d   = diffReg_q[0] ^ bReg_q[0] ^ carry_q;
    carry_d = (diffReg_q[0] & bReg_q[0]) |
              (diffReg_q[0] & carry_q)   |
              (bReg_q[0]    & carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      diffReg_q  <= '0;
      bReg_q     <= '0;
      resReg_q   <= '0;
      aOut_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      boutReg_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            diffReg_q <= bus.difference;
            bReg_q    <= bus.b;
            boutReg_q <= bus.bout;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          diffReg_q <= diffReg_q >> 1;
          bReg_q    <= bReg_q >> 1;
          resReg_q  <= {sum_d, resReg_q[WIDTH-1:1]};
          carry_q   <= carry_d;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == LastBit) begin
            state_q <= DONE;
          end
        end
        // First DONE edge publishes the result, second one releases the unit.
        DONE: begin
          if (!done_q) begin
            aOut_q     <= resReg_q;
            mismatch_q <= carry_q ^ boutReg_q;
            done_q     <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.a_out    = aOut_q;
  assign bus.mismatch = mismatch_q;

endmodule
